// File: rtl/div_share_ctrl.sv
// Shared radix-2 restoring divider for MIPS DIV/DIVU, arbitrated between the master and slave issue pipes.
// Grants are combinational in IDLE; results return with the owning pipe id and are held until the next done.
module div_share_ctrl #(
  parameter bit FIXED_PRIORITY = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        m_req,
  input  logic        m_signed,
  input  logic [31:0] m_a,
  input  logic [31:0] m_b,
  output logic        m_gnt,
  input  logic        s_req,
  input  logic        s_signed,
  input  logic [31:0] s_a,
  input  logic [31:0] s_b,
  output logic        s_gnt,
  output logic        busy,
  output logic        done,
  output logic        done_id,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_FIXUP,
    S_DONE
  } state_t;

  state_t      r_state;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_rem;
  logic [31:0] r_quo;
  logic [31:0] r_div;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [5:0]  r_cnt;
  logic        r_signed;
  logic        r_id;
  logic        r_lastSlave;

  logic        w_canGrant;
  logic        w_mWin;
  logic        w_sWin;
  logic        w_mGnt;
  logic        w_sGnt;
  logic [31:0] w_absA;
  logic [31:0] w_absB;
  logic [32:0] w_shift;
  logic [32:0] w_trial;

  // In round-robin mode a tie goes to the pipe that was not granted last.
  assign w_canGrant = (r_state == S_IDLE) && !flush && !rst;
  assign w_mWin     = m_req && (FIXED_PRIORITY || !s_req || r_lastSlave);
  assign w_sWin     = s_req && !w_mWin;
  assign w_mGnt     = w_canGrant && w_mWin;
  assign w_sGnt     = w_canGrant && w_sWin;

  assign w_absA = (r_signed && r_a[31]) ? -r_a : r_a;
  assign w_absB = (r_signed && r_b[31]) ? -r_b : r_b;

  // Partial remainder stays below the divisor, so a 33-bit trial keeps the sign in bit 32.
  assign w_shift = {r_rem, r_quo[31]};
  assign w_trial = w_shift - {1'b0, r_div};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_div       <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_cnt       <= '0;
      r_signed    <= 1'b0;
      r_id        <= 1'b0;
      r_lastSlave <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_mGnt || w_sGnt) begin
            r_a         <= w_mGnt ? m_a : s_a;
            r_b         <= w_mGnt ? m_b : s_b;
            r_signed    <= w_mGnt ? m_signed : s_signed;
            r_id        <= w_sGnt;
            r_lastSlave <= w_sGnt;
            r_state     <= S_PREP;
          end
        end
        S_PREP: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else if (r_b == 32'd0) begin
            r_hi    <= r_a;
            r_lo    <= 32'hFFFF_FFFF;
            r_state <= S_DONE;
          end else begin
            r_rem   <= '0;
            r_quo   <= w_absA;
            r_div   <= w_absB;
            r_cnt   <= '0;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else begin
            if (!w_trial[32]) begin
              r_rem <= w_trial[31:0];
              r_quo <= {r_quo[30:0], 1'b1};
            end else begin
              r_rem <= w_shift[31:0];
              r_quo <= {r_quo[30:0], 1'b0};
            end
            if (r_cnt == 6'd31) begin
              r_cnt   <= '0;
              r_state <= S_FIXUP;
            end else begin
              r_cnt <= r_cnt + 6'd1;
            end
          end
        end
        S_FIXUP: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else begin
            // Remainder takes the dividend's sign, as MIPS DIV defines it.
            r_lo    <= (r_signed && (r_a[31] ^ r_b[31])) ? -r_quo : r_quo;
            r_hi    <= (r_signed && r_a[31]) ? -r_rem : r_rem;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign m_gnt   = w_mGnt;
  assign s_gnt   = w_sGnt;
  assign busy    = (r_state != S_IDLE);
  assign done    = (r_state == S_DONE) && !flush;
  assign done_id = r_id;
  assign hi      = r_hi;
  assign lo      = r_lo;

endmodule

// File: tb/tb_div_share_ctrl.sv
// Bench for div_share_ctrl: a fixed-priority and a round-robin instance share one stimulus stream,
// each with its own scoreboard of expected results popped when that instance raises done.
module tb_div_share_ctrl;

  typedef struct {
    logic        id;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        m_req;
  logic        m_signed;
  logic [31:0] m_a;
  logic [31:0] m_b;
  logic        s_req;
  logic        s_signed;
  logic [31:0] s_a;
  logic [31:0] s_b;

  logic [1:0]  mGnt;
  logic [1:0]  sGnt;
  logic [1:0]  busyV;
  logic [1:0]  doneV;
  logic [1:0]  doneIdV;
  logic [31:0] hiV [2];
  logic [31:0] loV [2];

  exp_t        sbFp[$];
  exp_t        sbRr[$];
  logic [31:0] modelHi [2];
  logic [31:0] modelLo [2];

  int   cycleCnt   = 0;
  logic rstAtEdge  = 1'b0;
  int   assertions = 0;
  int   failures   = 0;
  int   grantCycle;

  div_share_ctrl #(.FIXED_PRIORITY(1'b1)) dutFp (
    .clk(clk), .rst(rst), .flush(flush),
    .m_req(m_req), .m_signed(m_signed), .m_a(m_a), .m_b(m_b), .m_gnt(mGnt[0]),
    .s_req(s_req), .s_signed(s_signed), .s_a(s_a), .s_b(s_b), .s_gnt(sGnt[0]),
    .busy(busyV[0]), .done(doneV[0]), .done_id(doneIdV[0]), .hi(hiV[0]), .lo(loV[0])
  );

  div_share_ctrl #(.FIXED_PRIORITY(1'b0)) dutRr (
    .clk(clk), .rst(rst), .flush(flush),
    .m_req(m_req), .m_signed(m_signed), .m_a(m_a), .m_b(m_b), .m_gnt(mGnt[1]),
    .s_req(s_req), .s_signed(s_signed), .s_a(s_a), .s_b(s_b), .s_gnt(sGnt[1]),
    .busy(busyV[1]), .done(doneV[1]), .done_id(doneIdV[1]), .hi(hiV[1]), .lo(loV[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    cycleCnt  = cycleCnt + 1;
    rstAtEdge = rst;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cycleCnt);
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    assertions++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic expv);
    checkOutput(tag, {31'b0, obs}, {31'b0, expv});
  endtask

  // Reference result from native integer division; timing is 35 cycles, or 2 for a zero divisor.
  function automatic exp_t model(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                 input logic id);
    exp_t e;
    int   sa;
    int   sbv;
    e.id  = id;
    e.cyc = cycleCnt + ((b == 32'd0) ? 2 : 35);
    if (b == 32'd0) begin
      e.hi = a;
      e.lo = 32'hFFFF_FFFF;
    end else if (!sgn) begin
      e.lo = a / b;
      e.hi = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.lo = 32'h8000_0000;
      e.hi = 32'h0;
    end else begin
      sa   = a;
      sbv  = b;
      e.lo = sa / sbv;
      e.hi = sa % sbv;
    end
    return e;
  endfunction

  task automatic applyStimulus(input logic mr, input logic ms, input logic [31:0] ma,
                               input logic [31:0] mb, input logic sr, input logic ss,
                               input logic [31:0] sa, input logic [31:0] sb);
    @(posedge clk);
    #1;
    m_req = mr; m_signed = ms; m_a = ma; m_b = mb;
    s_req = sr; s_signed = ss; s_a = sa; s_b = sb;
  endtask

  task automatic expectGrant(input string tag, input logic fm, input logic fs,
                             input logic rm, input logic rs);
    checkBit({tag, "/fp.m_gnt"}, mGnt[0], fm);
    checkBit({tag, "/fp.s_gnt"}, sGnt[0], fs);
    checkBit({tag, "/rr.m_gnt"}, mGnt[1], rm);
    checkBit({tag, "/rr.s_gnt"}, sGnt[1], rs);
    if (fm) sbFp.push_back(model(m_signed, m_a, m_b, 1'b0));
    if (fs) sbFp.push_back(model(s_signed, s_a, s_b, 1'b1));
    if (rm) sbRr.push_back(model(m_signed, m_a, m_b, 1'b0));
    if (rs) sbRr.push_back(model(s_signed, s_a, s_b, 1'b1));
  endtask

  task automatic waitIdle(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busyV != 2'b00 && n < 100);
    checkOutput({tag, "/idleTimeout"}, {30'b0, busyV}, 32'd0);
  endtask

  // Scoreboard pop on done, plus continuous hold checks on hi/lo and grant legality.
  always @(negedge clk) begin
    exp_t  e;
    string nm;
    for (int d = 0; d < 2; d++) begin
      nm = (d == 0) ? "fp" : "rr";
      if (rstAtEdge) begin
        modelHi[d] = '0;
        modelLo[d] = '0;
      end
      if (doneV[d] === 1'b1) begin
        if ((d == 0 && sbFp.size() == 0) || (d == 1 && sbRr.size() == 0)) begin
          checkBit({nm, "/unexpectedDone"}, doneV[d], 1'b0);
        end else begin
          if (d == 0) e = sbFp.pop_front();
          else        e = sbRr.pop_front();
          checkBit({nm, "/done_id"}, doneIdV[d], e.id);
          checkOutput({nm, "/doneCycle"}, cycleCnt, e.cyc);
          modelHi[d] = e.hi;
          modelLo[d] = e.lo;
        end
      end
      checkOutput({nm, "/hi"}, hiV[d], modelHi[d]);
      checkOutput({nm, "/lo"}, loV[d], modelLo[d]);
      checkBit({nm, "/gntOneHot"}, mGnt[d] & sGnt[d], 1'b0);
      checkBit({nm, "/gntWhileBusy"}, busyV[d] & (mGnt[d] | sGnt[d]), 1'b0);
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0;
    m_req = 1'b0; m_signed = 1'b0; m_a = '0; m_b = '0;
    s_req = 1'b0; s_signed = 1'b0; s_a = '0; s_b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checkBit("reset/busy", busyV[d], 1'b0);
      checkBit("reset/done", doneV[d], 1'b0);
      checkBit("reset/done_id", doneIdV[d], 1'b0);
      checkOutput("reset/hi", hiV[d], 32'd0);
      checkOutput("reset/lo", loV[d], 32'd0);
    end

    // Both pipes request and hold: fixed priority gives M,M,M; round-robin gives M,S,M.
    applyStimulus(1'b1, 1'b0, 32'd1000, 32'd10, 1'b1, 1'b1, 32'hFFFF_FF00, 32'd3);
    @(negedge clk);
    expectGrant("tie1", 1'b1, 1'b0, 1'b1, 1'b0);
    waitIdle("tie1");
    expectGrant("tie2", 1'b1, 1'b0, 1'b0, 1'b1);
    waitIdle("tie2");
    expectGrant("tie3", 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    waitIdle("tie3");

    applyStimulus(1'b1, 1'b0, 32'd100, 32'd7, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    expectGrant("divu", 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    waitIdle("divu");

    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2);
    @(negedge clk);
    expectGrant("divSlave", 1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    waitIdle("divSlave");

    applyStimulus(1'b1, 1'b0, 32'h1234, 32'd0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    expectGrant("div0", 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    waitIdle("div0");

    applyStimulus(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    expectGrant("overflow", 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    waitIdle("overflow");

    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9);
    @(negedge clk);
    expectGrant("negNeg", 1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    waitIdle("negNeg");

    // Flush in IDLE blocks the grant.
    applyStimulus(1'b1, 1'b0, 32'd9, 32'd3, 1'b0, 1'b0, '0, '0);
    flush = 1'b1;
    @(negedge clk);
    expectGrant("idleFlush", 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    flush = 1'b0;

    // Flush at T+10 mid-CALC; the waiting slave is granted at T+11.
    applyStimulus(1'b1, 1'b0, 32'd500, 32'd3, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    grantCycle = cycleCnt;
    expectGrant("flushM", 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 32'hFFFF_FFF0, 32'd5);
    repeat (9) @(posedge clk);
    #1;
    checkOutput("flush/cycle", cycleCnt, grantCycle + 10);
    flush = 1'b1;
    sbFp.delete();
    sbRr.delete();
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    checkOutput("flush/busyAfter", {30'b0, busyV}, 32'd0);
    expectGrant("flushS", 1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    waitIdle("flushS");

    // Reset at T+20 mid-CALC clears everything and no done follows.
    applyStimulus(1'b1, 1'b1, 32'hFFFF_8000, 32'd7, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    expectGrant("rstOp", 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    sbFp.delete();
    sbRr.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checkBit("midReset/busy", busyV[d], 1'b0);
      checkBit("midReset/done", doneV[d], 1'b0);
      checkBit("midReset/done_id", doneIdV[d], 1'b0);
      checkOutput("midReset/hi", hiV[d], 32'd0);
      checkOutput("midReset/lo", loV[d], 32'd0);
    end
    repeat (40) @(negedge clk);
    checkOutput("midReset/staysIdle", {30'b0, busyV}, 32'd0);

    checkOutput("end/sbFpEmpty", sbFp.size(), 32'd0);
    checkOutput("end/sbRrEmpty", sbRr.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/div_share_ctrl.md
# div_share_ctrl

Shared iterative divider and scheduler for MIPS DIV/DIVU, arbitrating one radix-2 restoring divide engine between the master and slave issue pipes of the dual-issue core. It sits beside the two execute-stage ALUs. It accepts one request per grant, runs a fixed-latency 32-iteration division, and returns quotient (LO) and remainder (HI) tagged with the requesting pipe. The pipeline flush aborts it.

## Interface
- FIXED_PRIORITY, default 1, selects arbitration: 1 = master always wins; 0 = round-robin between pipes.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  pipeline flush; aborts any in-flight division.
- m_req  in  1  master pipe requests a division.
- m_signed  in  1  master request is DIV (1) or DIVU (0).
- m_a  in  32  master dividend.
- m_b  in  32  master divisor.
- m_gnt  out  1  master request accepted this cycle.
- s_req  in  1  slave pipe request.
- s_signed  in  1  slave signed select.
- s_a  in  32  slave dividend.
- s_b  in  32  slave divisor.
- s_gnt  out  1  slave request accepted this cycle.
- busy  out  1  engine occupied; high whenever the state is not IDLE.
- done  out  1  one-cycle pulse; result valid.
- done_id  out  1  owner of the result: 0 = master, 1 = slave.
- hi  out  32  remainder; held until the next done.
- lo  out  32  quotient; held until the next done.

## Operation
- States: IDLE, PREP, CALC, FIXUP, DONE.
- IDLE:
  - Grants are combinational and issued only in IDLE with flush=0.
  - At most one of m_gnt/s_gnt is high in a cycle.
  - When a grant is issued, the engine latches the winner's a, b, signed and id, then moves to PREP.
- Arbitration with FIXED_PRIORITY=1: master wins whenever m_req=1.
- Arbitration with FIXED_PRIORITY=0:
  - When both pipes request, the pipe not granted last wins.
  - The last-grant register resets to slave, so master wins the first tie.
  - A lone requester always wins.
- PREP:
  - If b==0, go to DONE with hi=a (raw), lo=32'hFFFF_FFFF.
  - Otherwise form |a| and |b| when signed, using 32-bit two's-complement negation, and start a 6-bit iteration counter at 0. Go to CALC.
- CALC:
  - One restoring step per cycle: shift the remainder/quotient pair left, trial-subtract the divisor, keep the result if non-negative, set the quotient bit.
  - After 32 iterations (counter 31 -> wrap), go to FIXUP.
- FIXUP:
  - When signed, negate the quotient if a[31]^b[31].
  - When signed, negate the remainder if a[31] (remainder takes the dividend's sign).
  - Register hi/lo. Go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- 0x80000000 / 0xFFFFFFFF signed: lo=0x80000000, hi=0. This is the natural wrap result; no trap or flag.
- flush:
  - In PREP, CALC, FIXUP or DONE: next state is IDLE, done is suppressed (forced 0 in that cycle), and hi/lo keep their previous values.
  - In IDLE: suppresses grants.
- A request that is not granted must be held by the pipe (stall); the block does not queue requests.
- Reset: state IDLE, m_gnt=s_gnt=0, busy=0, done=0, done_id=0, hi=0, lo=0, counter 0, last-grant=slave.

## Timing
- Grant at cycle T (rising edge at the end of T captures operands).
- Normal divide:
  - PREP T+1.
  - CALC T+2..T+33.
  - FIXUP T+34.
  - DONE (done=1, hi/lo valid) T+35.
  - IDLE T+36; the earliest next grant is at T+36.
- Divide by zero: PREP T+1, DONE T+2, next grant T+3.
- busy is high from T+1 through the DONE cycle inclusive.
- hi/lo update on the same edge that enters DONE and are stable through and after the done pulse.
- flush at cycle F during an operation: busy=0 in F+1, and a grant is possible in F+1.
- Reset overrides flush and requests.

## Test plan
- DIVU by master: m_a=100, m_b=7 granted at T -> done at T+35, done_id=0, lo=14, hi=2.
- DIV by slave: s_a=0xFFFFFFF9 (-7), s_b=2 -> done at T+35, done_id=1, lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- Divide by zero: m_a=0x1234, m_b=0 -> done at T+2, hi=0x1234, lo=0xFFFFFFFF. Signed overflow: 0x80000000/0xFFFFFFFF signed -> lo=0x80000000, hi=0.
- Simultaneous m_req=s_req=1 held through three back-to-back operations:
  - FIXED_PRIORITY=1: grant order M, M, M.
  - FIXED_PRIORITY=0: grant order M, S, M.
  - In both cases no grant while busy=1 and gnt is one-hot.
- Flush in CALC at T+10 -> IDLE at T+11, no done pulse, hi/lo unchanged. A pending s_req is granted at T+11, and its done arrives 35 cycles later.
- rst asserted at T+20 mid-CALC -> next cycle all outputs 0 and state IDLE. No done is emitted for the aborted operation.
